// File: rtl/dm_pipe_pkg.sv
// dm_pipe shared definitions: op codes, lane constants, FSM states, latched request payload.
package dm_pipe_pkg;

  localparam int unsigned DM_DATA_W = 32;
  localparam int unsigned DM_ADDR_W = 32;
  localparam int unsigned DM_OP_W   = 3;
  localparam int unsigned DM_CNT_W  = 3;

  // Access op codes; 3'd7 is undefined and always faults.
  localparam logic [DM_OP_W-1:0] DM_OP_BS = 3'd0;
  localparam logic [DM_OP_W-1:0] DM_OP_BZ = 3'd1;
  localparam logic [DM_OP_W-1:0] DM_OP_HS = 3'd2;
  localparam logic [DM_OP_W-1:0] DM_OP_HZ = 3'd3;
  localparam logic [DM_OP_W-1:0] DM_OP_WD = 3'd4;
  localparam logic [DM_OP_W-1:0] DM_OP_SB = 3'd5;
  localparam logic [DM_OP_W-1:0] DM_OP_SH = 3'd6;

  // Big-endian byte enables: bit 3 covers word bits [31:24] (lane 0).
  localparam logic [3:0] DM_BE_LANE0 = 4'b1000;
  localparam logic [3:0] DM_BE_HALF0 = 4'b1100;
  localparam logic [3:0] DM_BE_HALF1 = 4'b0011;
  localparam logic [3:0] DM_BE_WORD  = 4'b1111;

  typedef enum logic [1:0] {
    DM_ST_IDLE = 2'd0,
    DM_ST_WAIT = 2'd1,
    DM_ST_RESP = 2'd2
  } dm_state_e;

  // Request attributes held while a load is in flight.
  typedef struct packed {
    logic               we;
    logic [DM_OP_W-1:0] op;
    logic [1:0]         lane;
    logic               err;
  } dm_req_t;

  // True when the op code is legal for the requested direction.
  function automatic logic dm_op_legal(input logic we, input logic [DM_OP_W-1:0] op);
    if (we) begin
      return (op == DM_OP_WD) || (op == DM_OP_SB) || (op == DM_OP_SH);
    end
    return (op == DM_OP_BS) || (op == DM_OP_BZ) || (op == DM_OP_HS) ||
           (op == DM_OP_HZ) || (op == DM_OP_WD);
  endfunction

endpackage

// File: rtl/dm_pipe_if.sv
// Request/response bus between the MEM stage (master) and dm_pipe (slave).
interface dm_pipe_if;

  logic                                req_valid;
  logic                                req_ready;
  logic                                req_we;
  logic [dm_pipe_pkg::DM_OP_W-1:0]     req_op;
  logic [dm_pipe_pkg::DM_ADDR_W-1:0]   req_addr;
  logic [dm_pipe_pkg::DM_DATA_W-1:0]   req_wdata;
  logic                                rsp_valid;
  logic [dm_pipe_pkg::DM_DATA_W-1:0]   rsp_rdata;
  logic                                rsp_err;

  modport master (
    output req_valid, req_we, req_op, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_op, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dm_pipe_lane.sv
// dm_lane: combinational big-endian lane steering for stores and loads.
// Optional macro DM_ALIGN_CHK_EN enables misaligned halfword/word detection.
module dm_lane
  import dm_pipe_pkg::*;
(
  input  logic [DM_OP_W-1:0]   i_op,
  input  logic [1:0]           i_lane,
  input  logic [DM_DATA_W-1:0] i_wdata,
  input  logic [DM_DATA_W-1:0] i_rword,
  output logic [3:0]           o_be_c,
  output logic [DM_DATA_W-1:0] o_wword_c,
  output logic [DM_DATA_W-1:0] o_rdata_c,
  output logic                 o_misalign_c
);

  logic [4:0]  w_bshift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane k sits at bits [31-8k:24-8k], so shift right by 8*(3-k).
  assign w_bshift = {~i_lane, 3'b000};
  assign w_byte   = 8'(i_rword >> w_bshift);
  assign w_half   = i_lane[1] ? i_rword[15:0] : i_rword[31:16];

  // Store byte enables and replicated write data.
  always_comb begin
    o_be_c    = 4'b0000;
    o_wword_c = '0;
    case (i_op)
      DM_OP_SB: begin
        o_be_c    = DM_BE_LANE0 >> i_lane;
        o_wword_c = {4{i_wdata[7:0]}};
      end
      DM_OP_SH: begin
        o_be_c    = i_lane[1] ? DM_BE_HALF1 : DM_BE_HALF0;
        o_wword_c = {2{i_wdata[15:0]}};
      end
      DM_OP_WD: begin
        o_be_c    = DM_BE_WORD;
        o_wword_c = i_wdata;
      end
      default: begin
        o_be_c    = 4'b0000;
        o_wword_c = '0;
      end
    endcase
  end

  // Load extract with sign or zero extension.
  always_comb begin
    o_rdata_c = '0;
    case (i_op)
      DM_OP_BS: o_rdata_c = {{24{w_byte[7]}}, w_byte};
      DM_OP_BZ: o_rdata_c = {24'd0, w_byte};
      DM_OP_HS: o_rdata_c = {{16{w_half[15]}}, w_half};
      DM_OP_HZ: o_rdata_c = {16'd0, w_half};
      DM_OP_WD: o_rdata_c = i_rword;
      default:  o_rdata_c = '0;
    endcase
  end

  // Misalignment flag: halfwords need addr[0]=0, words need addr[1:0]=0.
  always_comb begin
    o_misalign_c = 1'b0;
`ifdef DM_ALIGN_CHK_EN
    if ((i_op == DM_OP_HS) || (i_op == DM_OP_HZ) || (i_op == DM_OP_SH)) begin
      o_misalign_c = i_lane[0];
    end else if (i_op == DM_OP_WD) begin
      o_misalign_c = (i_lane != 2'b00);
    end
`endif
  end

endmodule

// File: rtl/dm_pipe.sv
// dm_pipe: data memory with valid/ready request, configurable read latency and
// byte/halfword/word access. Alignment faults are compiled in with DM_ALIGN_CHK_EN.
module dm_pipe
  import dm_pipe_pkg::*;
#(
  parameter int unsigned NMEM   = 256,
  parameter int unsigned NBIT   = $clog2(NMEM),
  parameter int unsigned RD_LAT = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  dm_pipe_if.slave  bus
);

  localparam int unsigned CNT_W = DM_CNT_W;

  logic [DM_DATA_W-1:0] r_mem [NMEM];

  dm_state_e            r_state;
  dm_state_e            w_state_n;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_n;
  dm_req_t              r_req;
  logic [NBIT-1:0]      r_idx;

  logic                 r_req_ready;
  logic                 r_rsp_valid;
  logic                 r_rsp_err;
  logic [DM_DATA_W-1:0] r_rsp_rdata;

  logic                 w_req_ready_n;
  logic                 w_rsp_valid_n;
  logic                 w_rsp_err_n;
  logic [DM_DATA_W-1:0] w_rsp_rdata_n;

  logic                 w_accept;
  logic                 w_oor;
  logic                 w_req_err;
  logic                 w_wr_en;
  logic                 w_idle;

  logic                 w_act_we;
  logic [DM_OP_W-1:0]   w_act_op;
  logic [1:0]           w_act_lane;
  logic                 w_act_err;
  logic [NBIT-1:0]      w_act_idx;

  logic [3:0]           w_be;
  logic [DM_DATA_W-1:0] w_wword;
  logic [DM_DATA_W-1:0] w_rdata;
  logic [DM_DATA_W-1:0] w_rword;
  logic                 w_misalign;

  assign w_idle   = (r_state == DM_ST_IDLE);
  assign w_accept = rst_n && bus.req_valid && r_req_ready;

  // Any address bit above the word index faults.
  assign w_oor     = (bus.req_addr >> (NBIT + 2)) != 32'd0;
  assign w_req_err = !dm_op_legal(bus.req_we, bus.req_op) || w_oor || w_misalign;

  // Active request: live bus fields while idle, latched fields while a load is pending.
  assign w_act_we   = w_idle ? bus.req_we              : r_req.we;
  assign w_act_op   = w_idle ? bus.req_op              : r_req.op;
  assign w_act_lane = w_idle ? bus.req_addr[1:0]       : r_req.lane;
  assign w_act_idx  = w_idle ? bus.req_addr[NBIT+1:2]  : r_idx;
  assign w_act_err  = w_idle ? w_req_err               : r_req.err;
  assign w_rword    = r_mem[w_act_idx];

  dm_lane u_lane (
    .i_op         (w_act_op),
    .i_lane       (w_act_lane),
    .i_wdata      (bus.req_wdata),
    .i_rword      (w_rword),
    .o_be_c       (w_be),
    .o_wword_c    (w_wword),
    .o_rdata_c    (w_rdata),
    .o_misalign_c (w_misalign)
  );

  // FSM state and latency counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= DM_ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end

  // Next state, write strobe and next response values.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_wr_en   = 1'b0;
    case (r_state)
      DM_ST_IDLE: begin
        if (w_accept) begin
          w_wr_en = bus.req_we && !w_req_err;
          if (bus.req_we || (RD_LAT == 1)) begin
            w_state_n = DM_ST_RESP;
          end else begin
            w_state_n = DM_ST_WAIT;
            w_cnt_n   = CNT_W'(RD_LAT - 1);
          end
        end
      end
      DM_ST_WAIT: begin
        if (r_cnt <= CNT_W'(1)) begin
          w_state_n = DM_ST_RESP;
          w_cnt_n   = '0;
        end else begin
          w_cnt_n = r_cnt - CNT_W'(1);
        end
      end
      DM_ST_RESP: w_state_n = DM_ST_IDLE;
      default:    w_state_n = DM_ST_IDLE;
    endcase
    w_req_ready_n = (w_state_n == DM_ST_IDLE);
    w_rsp_valid_n = (w_state_n == DM_ST_RESP);
    w_rsp_err_n   = w_rsp_valid_n && w_act_err;
    w_rsp_rdata_n = (w_rsp_valid_n && !w_act_we && !w_act_err) ? w_rdata : '0;
  end

  // Registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_req_ready <= w_req_ready_n;
      r_rsp_valid <= w_rsp_valid_n;
      r_rsp_err   <= w_rsp_err_n;
      r_rsp_rdata <= w_rsp_rdata_n;
    end
  end

  // Capture request attributes on acceptance for the delayed load path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req <= '0;
      r_idx <= '0;
    end else if (w_accept) begin
      r_req <= '{we: bus.req_we, op: bus.req_op, lane: bus.req_addr[1:0], err: w_req_err};
      r_idx <= bus.req_addr[NBIT+1:2];
    end
  end

  // Word array with per-byte write enables; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      if (w_be[3]) r_mem[w_act_idx][31:24] <= w_wword[31:24];
      if (w_be[2]) r_mem[w_act_idx][23:16] <= w_wword[23:16];
      if (w_be[1]) r_mem[w_act_idx][15:8]  <= w_wword[15:8];
      if (w_be[0]) r_mem[w_act_idx][7:0]   <= w_wword[7:0];
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_dm_pipe.sv
// Self-checking bench for dm_pipe (NMEM=256, RD_LAT=3) with a byte-addressed reference model.
module tb_dm_pipe;
  import dm_pipe_pkg::*;

  localparam int unsigned NMEM   = 256;
  localparam int unsigned RD_LAT = 3;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  // Reference memory: big-endian byte array, byte a holds address a.
  logic [7:0] m_bytes [0:NMEM*4-1];

  dm_pipe_if bus ();

  dm_pipe #(.NMEM(NMEM), .RD_LAT(RD_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour of a single access, updating the byte model for stores.
  function automatic void ref_access(input logic we, input logic [2:0] op, input logic [31:0] addr,
                                     input logic [31:0] wd, output logic [31:0] rd, output logic er);
    logic       is_half;
    logic [9:0] a;
    is_half = (op == DM_OP_HS) || (op == DM_OP_HZ) || (op == DM_OP_SH);
    if (we) er = !((op == DM_OP_WD) || (op == DM_OP_SB) || (op == DM_OP_SH));
    else    er = !((op == DM_OP_BS) || (op == DM_OP_BZ) || (op == DM_OP_HS) ||
                   (op == DM_OP_HZ) || (op == DM_OP_WD));
    if (addr >= 32'(NMEM * 4)) er = 1'b1;
`ifdef DM_ALIGN_CHK_EN
    if (is_half && addr[0]) er = 1'b1;
    if ((op == DM_OP_WD) && (addr[1:0] != 2'b00)) er = 1'b1;
`endif
    rd = 32'd0;
    if (er) return;
    a = addr[9:0];
    if (is_half) a = a & 10'h3FE;
    if (op == DM_OP_WD) a = a & 10'h3FC;
    if (we) begin
      case (op)
        DM_OP_SB: m_bytes[a] = wd[7:0];
        DM_OP_SH: begin m_bytes[a] = wd[15:8]; m_bytes[a+1] = wd[7:0]; end
        default: begin
          m_bytes[a] = wd[31:24]; m_bytes[a+1] = wd[23:16];
          m_bytes[a+2] = wd[15:8]; m_bytes[a+3] = wd[7:0];
        end
      endcase
    end else begin
      case (op)
        DM_OP_BS: rd = {{24{m_bytes[a][7]}}, m_bytes[a]};
        DM_OP_BZ: rd = {24'd0, m_bytes[a]};
        DM_OP_HS: rd = {{16{m_bytes[a][7]}}, m_bytes[a], m_bytes[a+1]};
        DM_OP_HZ: rd = {16'd0, m_bytes[a], m_bytes[a+1]};
        default:  rd = {m_bytes[a], m_bytes[a+1], m_bytes[a+2], m_bytes[a+3]};
      endcase
    end
  endfunction

  // Issue one request from idle and collect its response; lat=0 means no response seen.
  task automatic do_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat, output bit busy_ok, output bit pulse_ok,
                        output bit pre_ready);
    @(negedge clk);
    pre_ready     = bus.req_ready;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 0; busy_ok = 1'b1; pulse_ok = 1'b0; rd = 32'd0; er = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      if (bus.req_ready) busy_ok = 1'b0;
      if (bus.rsp_valid) begin
        lat = k; rd = bus.rsp_rdata; er = bus.rsp_err;
        break;
      end
    end
    if (lat != 0) begin
      @(negedge clk);
      pulse_ok = !bus.rsp_valid && bus.req_ready;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready); end
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.rsp_valid); end
    n_checks++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", bus.rsp_err); end
    n_checks++; if (bus.rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", bus.rsp_rdata); end
  endtask

  task automatic test_word_round_trip();
    logic [31:0] rd; logic er; int lat; bit bo, po, pr;
    do_req(1'b1, DM_OP_WD, 32'h10, 32'hDEADBEEF, rd, er, lat, bo, po, pr);
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL st_lat got=%0d exp=1", lat); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL st_err got=%b exp=0", er); end
    n_checks++; if (!po) begin n_fail++; $display("FAIL st_pulse got=0 exp=1"); end
    do_req(1'b0, DM_OP_WD, 32'h10, 32'h0, rd, er, lat, bo, po, pr);
    n_checks++; if (lat != RD_LAT) begin n_fail++; $display("FAIL ld_lat got=%0d exp=%0d", lat, RD_LAT); end
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ld_word got=%h exp=deadbeef", rd); end
    n_checks++; if (!bo) begin n_fail++; $display("FAIL ld_busy got=ready_seen exp=ready_low"); end
    n_checks++; if (!po) begin n_fail++; $display("FAIL ld_pulse got=0 exp=1"); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic er; int lat; bit bo, po, pr;
    do_req(1'b1, DM_OP_WD, 32'h20, 32'h11223344, rd, er, lat, bo, po, pr);
    do_req(1'b1, DM_OP_SB, 32'h22, 32'h000000AA, rd, er, lat, bo, po, pr);
    do_req(1'b0, DM_OP_WD, 32'h20, 32'h0, rd, er, lat, bo, po, pr);
    n_checks++; if (rd !== 32'h1122AA44) begin n_fail++; $display("FAIL sb_word got=%h exp=1122aa44", rd); end
    do_req(1'b0, DM_OP_BS, 32'h22, 32'h0, rd, er, lat, bo, po, pr);
    n_checks++; if (rd !== 32'hFFFFFFAA) begin n_fail++; $display("FAIL ld_bs got=%h exp=ffffffaa", rd); end
    do_req(1'b0, DM_OP_BZ, 32'h22, 32'h0, rd, er, lat, bo, po, pr);
    n_checks++; if (rd !== 32'h000000AA) begin n_fail++; $display("FAIL ld_bz got=%h exp=000000aa", rd); end
    do_req(1'b0, DM_OP_BZ, 32'h23, 32'h0, rd, er, lat, bo, po, pr);
    n_checks++; if (rd !== 32'h00000044) begin n_fail++; $display("FAIL ld_bz3 got=%h exp=00000044", rd); end
  endtask

  task automatic test_halfwords();
    logic [31:0] rd; logic er; int lat; bit bo, po, pr;
    do_req(1'b1, DM_OP_WD, 32'h30, 32'h0, rd, er, lat, bo, po, pr);
    do_req(1'b1, DM_OP_SH, 32'h32, 32'hFFFF8001, rd, er, lat, bo, po, pr);
    do_req(1'b0, DM_OP_WD, 32'h30, 32'h0, rd, er, lat, bo, po, pr);
    n_checks++; if (rd !== 32'h00008001) begin n_fail++; $display("FAIL sh_word got=%h exp=00008001", rd); end
    do_req(1'b0, DM_OP_HS, 32'h32, 32'h0, rd, er, lat, bo, po, pr);
    n_checks++; if (rd !== 32'hFFFF8001) begin n_fail++; $display("FAIL ld_hs got=%h exp=ffff8001", rd); end
    do_req(1'b0, DM_OP_HZ, 32'h30, 32'h0, rd, er, lat, bo, po, pr);
    n_checks++; if (rd !== 32'h00000000) begin n_fail++; $display("FAIL ld_hz got=%h exp=00000000", rd); end
  endtask

  task automatic test_faults();
    logic [31:0] rd; logic er; int lat; bit bo, po, pr;
    do_req(1'b0, DM_OP_WD, 32'h00010000, 32'h0, rd, er, lat, bo, po, pr);
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL oor_err got=%b exp=1", er); end
    n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL oor_rdata got=%h exp=0", rd); end
    n_checks++; if (lat != RD_LAT) begin n_fail++; $display("FAIL oor_lat got=%0d exp=%0d", lat, RD_LAT); end
    do_req(1'b1, DM_OP_WD, 32'h00010010, 32'h12345678, rd, er, lat, bo, po, pr);
    n_checks++; if (er !== 1'b1 || lat != 1) begin n_fail++; $display("FAIL oor_st got=err%b/lat%0d exp=err1/lat1", er, lat); end
    do_req(1'b1, DM_OP_BS, 32'h10, 32'h0, rd, er, lat, bo, po, pr);
    n_checks++; if (er !== 1'b1 || lat != 1) begin n_fail++; $display("FAIL st_ldop got=err%b/lat%0d exp=err1/lat1", er, lat); end
    do_req(1'b0, DM_OP_SB, 32'h10, 32'h0, rd, er, lat, bo, po, pr);
    n_checks++; if (er !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL ld_stop got=err%b/%h exp=err1/0", er, rd); end
    do_req(1'b1, 3'd7, 32'h10, 32'h0, rd, er, lat, bo, po, pr);
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL undef_op got=%b exp=1", er); end
    do_req(1'b0, DM_OP_WD, 32'h10, 32'h0, rd, er, lat, bo, po, pr);
    n_checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_fail++; $display("FAIL fault_noeff got=%h exp=deadbeef", rd); end
`ifdef DM_ALIGN_CHK_EN
    do_req(1'b1, DM_OP_SH, 32'h33, 32'h00001234, rd, er, lat, bo, po, pr);
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL align_sh got=%b exp=1", er); end
    do_req(1'b0, DM_OP_WD, 32'h30, 32'h0, rd, er, lat, bo, po, pr);
    n_checks++; if (rd !== 32'h00008001) begin n_fail++; $display("FAIL align_keep got=%h exp=00008001", rd); end
    do_req(1'b0, DM_OP_WD, 32'h31, 32'h0, rd, er, lat, bo, po, pr);
    n_checks++; if (er !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL align_wd got=err%b/%h exp=err1/0", er, rd); end
`else
    do_req(1'b1, DM_OP_SH, 32'h33, 32'h00001234, rd, er, lat, bo, po, pr);
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL noalign_sh got=%b exp=0", er); end
    do_req(1'b0, DM_OP_WD, 32'h31, 32'h0, rd, er, lat, bo, po, pr);
    n_checks++; if (rd !== 32'h00001234 || er !== 1'b0) begin n_fail++; $display("FAIL noalign_wd got=%h exp=00001234", rd); end
`endif
  endtask

  task automatic test_back_to_back();
    int t0, t1, cyc;
    t0 = -1; t1 = -1; cyc = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_op = DM_OP_WD;
    bus.req_addr = 32'h10; bus.req_wdata = 32'h0;
    while (cyc < 40 && t1 < 0) begin
      @(negedge clk);
      cyc++;
      if (bus.rsp_valid) begin
        if (t0 < 0) t0 = cyc; else t1 = cyc;
      end
    end
    bus.req_valid = 1'b0;
    n_checks++; if (t1 - t0 != int'(RD_LAT + 1) || t0 < 0) begin n_fail++; $display("FAIL b2b_gap got=%0d exp=%0d", t1 - t0, RD_LAT + 1); end
    repeat (RD_LAT + 2) @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] rd, exp_rd, addr, wd; logic er, exp_er, we; logic [2:0] op;
    int lat; bit bo, po, pr; int bad;
    for (int w = 0; w < 16; w++) begin
      wd = $urandom;
      ref_access(1'b1, DM_OP_WD, 32'h100 + 32'(w * 4), wd, exp_rd, exp_er);
      do_req(1'b1, DM_OP_WD, 32'h100 + 32'(w * 4), wd, rd, er, lat, bo, po, pr);
    end
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      we   = 1'($urandom_range(0, 1));
      op   = 3'($urandom_range(0, 7));
      addr = 32'h100 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) addr = addr | 32'h0004_0000;
      wd   = $urandom;
      ref_access(we, op, addr, wd, exp_rd, exp_er);
      do_req(we, op, addr, wd, rd, er, lat, bo, po, pr);
      n_checks++;
      if (er !== exp_er || (!we && rd !== exp_rd) || lat != (we ? 1 : int'(RD_LAT)) || !pr || !po) begin
        n_fail++;
        if (bad < 10) $display("FAIL rand_%0d we=%b op=%0d addr=%h got=%h/err%b/lat%0d exp=%h/err%b", i, we, op, addr, rd, er, lat, exp_rd, exp_er);
        bad++;
      end
    end
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] rd; logic er; int lat; bit bo, po, pr; bit seen;
    seen = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_op = DM_OP_WD;
    bus.req_addr = 32'h10; bus.req_wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (bus.rsp_valid) seen = 1'b1;
    @(negedge clk);
    if (bus.rsp_valid) seen = 1'b1;
    rst_n = 1'b0;
    repeat (2) begin @(negedge clk); if (bus.rsp_valid) seen = 1'b1; end
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got=%b exp=1", bus.req_ready); end
    repeat (6) begin @(negedge clk); if (bus.rsp_valid) seen = 1'b1; end
    n_checks++; if (seen) begin n_fail++; $display("FAIL rstmid_norsp got=rsp exp=none"); end
    do_req(1'b0, DM_OP_WD, 32'h10, 32'h0, rd, er, lat, bo, po, pr);
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rstmid_data got=%h exp=deadbeef", rd); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_addr  = 32'd0;
    bus.req_wdata = 32'd0;
    test_reset();
    test_word_round_trip();
    test_byte_lanes();
    test_halfwords();
    test_faults();
    test_back_to_back();
    test_random();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
